// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register for the pipelined MIPS core, with load-use hazard
// detection, bubble insertion, branch flush and saturating stall/flush counters.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [5:0]            id_opcode_i,
  input  logic [5:0]            id_func_i,
  input  logic [4:0]            id_shamt_i,
  input  logic [4:0]            id_rs_i,
  input  logic [4:0]            id_rt_i,
  input  logic [4:0]            id_rd_i,
  input  logic [DATA_WIDTH-1:0] id_rs_data_i,
  input  logic [DATA_WIDTH-1:0] id_rt_data_i,
  input  logic [DATA_WIDTH-1:0] id_imm_i,
  input  logic [DATA_WIDTH-1:0] id_pc4_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_mem_to_reg_i,
  input  logic                  flush_i,
  output logic                  ex_valid_o,
  output logic [5:0]            ex_opcode_o,
  output logic [5:0]            ex_func_o,
  output logic [4:0]            ex_shamt_o,
  output logic [4:0]            ex_rs_o,
  output logic [4:0]            ex_rt_o,
  output logic [4:0]            ex_rd_o,
  output logic [DATA_WIDTH-1:0] ex_rs_data_o,
  output logic [DATA_WIDTH-1:0] ex_rt_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [DATA_WIDTH-1:0] ex_pc4_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_mem_to_reg_o,
  output logic                  stall_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic [5:0]            opcode;
    logic [5:0]            func;
    logic [4:0]            shamt;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc4;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
  } stage_t;

  // Opcode/func of all-ones keep the shift decoder (SLL 0/0, SRL 0/2) quiet on bubbles.
  function automatic stage_t bubble_f();
    stage_t b;
    b        = '0;
    b.opcode = 6'h3F;
    b.func   = 6'h3F;
    return b;
  endfunction

  stage_t stage_q;
  stage_t stage_d;
  logic   hazard;

  assign hazard = stage_q.valid & stage_q.mem_read & id_valid_i &
                  (stage_q.rt != 5'd0) &
                  ((stage_q.rt == id_rs_i) | (stage_q.rt == id_rt_i));
  assign stall_o = hazard & ~flush_i;

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    stage_d = bubble_f();
    if (!flush_i && !stall_o) begin
      stage_d.valid      = id_valid_i;
      stage_d.opcode     = id_valid_i ? id_opcode_i : 6'h3F;
      stage_d.func       = id_valid_i ? id_func_i : 6'h3F;
      stage_d.shamt      = id_shamt_i;
      stage_d.rs         = id_rs_i;
      stage_d.rt         = id_rt_i;
      stage_d.rd         = id_rd_i;
      stage_d.rs_data    = id_rs_data_i;
      stage_d.rt_data    = id_rt_data_i;
      stage_d.imm        = id_imm_i;
      stage_d.pc4        = id_pc4_i;
      stage_d.reg_write  = id_valid_i & id_reg_write_i;
      stage_d.mem_read   = id_valid_i & id_mem_read_i;
      stage_d.mem_write  = id_valid_i & id_mem_write_i;
      stage_d.mem_to_reg = id_valid_i & id_mem_to_reg_i;
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is asynchronous active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q     <= bubble_f();
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      stage_q <= stage_d;
      if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
      if (flush_i && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
    end
  end

  assign ex_valid_o      = stage_q.valid;
  assign ex_opcode_o     = stage_q.opcode;
  assign ex_func_o       = stage_q.func;
  assign ex_shamt_o      = stage_q.shamt;
  assign ex_rs_o         = stage_q.rs;
  assign ex_rt_o         = stage_q.rt;
  assign ex_rd_o         = stage_q.rd;
  assign ex_rs_data_o    = stage_q.rs_data;
  assign ex_rt_data_o    = stage_q.rt_data;
  assign ex_imm_o        = stage_q.imm;
  assign ex_pc4_o        = stage_q.pc4;
  assign ex_reg_write_o  = stage_q.reg_write;
  assign ex_mem_read_o   = stage_q.mem_read;
  assign ex_mem_write_o  = stage_q.mem_write;
  assign ex_mem_to_reg_o = stage_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Scoreboard bench for id_ex_stage_register: directed steps push hand-computed
// expectations; a monitor compares stall_o before each edge and ex_*/counters after it.
module tb_id_ex_stage_register;
  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic          valid;
    logic [5:0]    opcode;
    logic [5:0]    func;
    logic [4:0]    shamt;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [3:0]    ctl;  // {reg_write, mem_read, mem_write, mem_to_reg}
  } in_t;

  typedef struct packed {
    logic          stall;
    in_t           ex;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  in_t  drv = '0;
  in_t  act;
  logic stall;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r;
  logic [5:0] ex_opcode, ex_func;
  logic [4:0] ex_shamt, ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  id_ex_stage_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(drv.valid), .id_opcode_i(drv.opcode), .id_func_i(drv.func),
    .id_shamt_i(drv.shamt), .id_rs_i(drv.rs), .id_rt_i(drv.rt), .id_rd_i(drv.rd),
    .id_rs_data_i(drv.rs_data), .id_rt_data_i(drv.rt_data),
    .id_imm_i(drv.imm), .id_pc4_i(drv.pc4),
    .id_reg_write_i(drv.ctl[3]), .id_mem_read_i(drv.ctl[2]),
    .id_mem_write_i(drv.ctl[1]), .id_mem_to_reg_i(drv.ctl[0]),
    .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_opcode_o(ex_opcode), .ex_func_o(ex_func),
    .ex_shamt_o(ex_shamt), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
    .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
    .ex_imm_o(ex_imm), .ex_pc4_o(ex_pc4),
    .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr),
    .ex_mem_write_o(ex_mw), .ex_mem_to_reg_o(ex_m2r),
    .stall_o(stall), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  assign act = {ex_valid, ex_opcode, ex_func, ex_shamt, ex_rs, ex_rt, ex_rd,
                ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rw, ex_mr, ex_mw, ex_m2r};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  function automatic in_t mk(input logic v, input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [DW-1:0] rsd,
                             input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                             input logic [DW-1:0] pc4, input logic [3:0] ctl);
    in_t r;
    r = '{valid: v, opcode: op, func: fn, shamt: sh, rs: rs, rt: rt, rd: rd,
          rs_data: rsd, rt_data: rtd, imm: imm, pc4: pc4, ctl: ctl};
    return r;
  endfunction

  function automatic in_t bub();
    return mk(1'b0, 6'h3F, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0, 4'b0000);
  endfunction

  function automatic exp_t e(input logic st, input in_t ex, input logic [CW-1:0] sc,
                             input logic [CW-1:0] fc);
    exp_t r;
    r = '{stall: st, ex: ex, scnt: sc, fcnt: fc};
    return r;
  endfunction

  // One cycle: drive ID inputs at the falling edge, record what must follow.
  task automatic step(input in_t v, input logic fl, input logic rst, input exp_t x);
    @(negedge clk);
    drv   = v;
    flush = fl;
    reset = rst;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      s = stall;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        check("stall_o",    {63'd0, s},               {63'd0, x.stall});
        check("ex_valid",   {63'd0, act.valid},       {63'd0, x.ex.valid});
        check("ex_opcode",  {58'd0, act.opcode},      {58'd0, x.ex.opcode});
        check("ex_func",    {58'd0, act.func},        {58'd0, x.ex.func});
        check("ex_shamt",   {59'd0, act.shamt},       {59'd0, x.ex.shamt});
        check("ex_rs",      {59'd0, act.rs},          {59'd0, x.ex.rs});
        check("ex_rt",      {59'd0, act.rt},          {59'd0, x.ex.rt});
        check("ex_rd",      {59'd0, act.rd},          {59'd0, x.ex.rd});
        check("ex_rs_data", {32'd0, act.rs_data},     {32'd0, x.ex.rs_data});
        check("ex_rt_data", {32'd0, act.rt_data},     {32'd0, x.ex.rt_data});
        check("ex_imm",     {32'd0, act.imm},         {32'd0, x.ex.imm});
        check("ex_pc4",     {32'd0, act.pc4},         {32'd0, x.ex.pc4});
        check("ex_ctl",     {60'd0, act.ctl},         {60'd0, x.ex.ctl});
        check("stall_cnt",  {60'd0, stall_cnt},       {60'd0, x.scnt});
        check("flush_cnt",  {60'd0, flush_cnt},       {60'd0, x.fcnt});
      end
    end
  end

  initial begin : stimulus
    logic [191:0] r;
    in_t sll, lw8, add8, lw0, use0, oth, add_fl, idle, idle_ex, lw5, lw6, add6;

    sll    = mk(1, 6'h00, 6'h00, 5'd4, 5'd0,  5'd9,  5'd10, 32'h0, 32'h0000_00F1, 32'h100, 32'h4, 4'b1000);
    lw8    = mk(1, 6'h23, 6'h00, 5'd0, 5'd29, 5'd8,  5'd0,  32'h1000, 32'h55, 32'h10, 32'h8, 4'b1101);
    add8   = mk(1, 6'h00, 6'h20, 5'd0, 5'd8,  5'd9,  5'd11, 32'hA, 32'hB, 32'h0, 32'hC, 4'b1000);
    lw0    = mk(1, 6'h23, 6'h00, 5'd0, 5'd29, 5'd0,  5'd0,  32'h1000, 32'h0, 32'h20, 32'h10, 4'b1101);
    use0   = mk(1, 6'h00, 6'h20, 5'd0, 5'd0,  5'd0,  5'd12, 32'h0, 32'h0, 32'h0, 32'h14, 4'b1000);
    oth    = mk(1, 6'h00, 6'h22, 5'd0, 5'd9,  5'd10, 5'd13, 32'h7, 32'h3, 32'h0, 32'h1C, 4'b1000);
    add_fl = mk(1, 6'h00, 6'h20, 5'd0, 5'd8,  5'd1,  5'd14, 32'h1, 32'h2, 32'h0, 32'h24, 4'b1000);
    idle   = mk(0, 6'h00, 6'h02, 5'd3, 5'd1,  5'd2,  5'd3,  32'hDEAD, 32'hBEEF, 32'h44, 32'h28, 4'b1111);
    idle_ex = mk(0, 6'h3F, 6'h3F, 5'd3, 5'd1, 5'd2,  5'd3,  32'hDEAD, 32'hBEEF, 32'h44, 32'h28, 4'b0000);
    lw5    = mk(1, 6'h23, 6'h00, 5'd0, 5'd4,  5'd5,  5'd0,  32'h2000, 32'h0, 32'h8, 32'h2C, 4'b1101);
    lw6    = mk(1, 6'h23, 6'h00, 5'd0, 5'd5,  5'd6,  5'd0,  32'h2004, 32'h0, 32'hC, 32'h30, 4'b1101);
    add6   = mk(1, 6'h00, 6'h20, 5'd0, 5'd6,  5'd7,  5'd15, 32'h5, 32'h6, 32'h0, 32'h34, 4'b1000);

    r   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drv = r[$bits(in_t)-1:0];
    #1 reset = 1'b0;

    // Reset holds bubble state regardless of ID inputs.
    for (int i = 0; i < 2; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(r[$bits(in_t)-1:0], 1'b0, 1'b0, e(0, bub(), 4'd0, 4'd0));
    end

    step(sll,  0, 1, e(0, sll,   4'd0, 4'd0));   // first edge after release loads
    step(lw8,  0, 1, e(0, lw8,   4'd0, 4'd0));
    step(add8, 0, 1, e(1, bub(), 4'd1, 4'd0));   // load-use: stall + bubble
    step(add8, 0, 1, e(0, add8,  4'd1, 4'd0));   // issues on the following edge
    step(lw0,  0, 1, e(0, lw0,   4'd1, 4'd0));
    step(use0, 0, 1, e(0, use0,  4'd1, 4'd0));   // $zero never hazards
    step(lw8,  0, 1, e(0, lw8,   4'd1, 4'd0));
    step(oth,  0, 1, e(0, oth,   4'd1, 4'd0));   // unrelated registers
    step(lw8,  0, 1, e(0, lw8,   4'd1, 4'd0));
    step(add_fl, 1, 1, e(0, bub(), 4'd1, 4'd1)); // flush beats stall
    step(idle, 0, 1, e(0, idle_ex, 4'd1, 4'd1)); // invalid: data passes, control killed
    step(lw5,  0, 1, e(0, lw5,   4'd1, 4'd1));
    step(lw6,  0, 1, e(1, bub(), 4'd2, 4'd1));   // dependent load chain alternates
    step(lw6,  0, 1, e(0, lw6,   4'd2, 4'd1));
    step(add6, 0, 1, e(1, bub(), 4'd3, 4'd1));
    step(add6, 0, 1, e(0, add6,  4'd3, 4'd1));

    // Flush counter saturates at 4'hF.
    for (int k = 1; k <= 20; k++) begin
      step(sll, 1, 1, e(0, bub(), 4'd3, (k + 1 >= 15) ? 4'hF : 4'(k + 1)));
    end

    // Reset mid-stream, then the first edge after release loads.
    step(sll, 0, 0, e(0, bub(), 4'd0, 4'd0));
    step(sll, 0, 1, e(0, sll,   4'd0, 4'd0));

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_register.md
# id_ex_stage_register

ID/EX pipeline register with integrated load-use hazard detection for the pipelined MIPS core. It captures the decoded instruction fields, register operands and control bits from the decode stage and presents them, registered, to the execute stage. The execute stage includes the shift unit, which receives opcode, func, shamt and rt data from this block. The block also detects load-use hazards, stalls the front end, inserts bubbles, honours branch flushes, and keeps stall/flush event counters.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width
- CNT_WIDTH, 16, width of stall and flush event counters

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid_i  in  1  decode stage holds a real instruction
- id_opcode_i  in  6  instruction[31:26]
- id_func_i  in  6  instruction[5:0]
- id_shamt_i  in  5  instruction[10:6]
- id_rs_i, id_rt_i, id_rd_i  in  5 each  register specifiers
- id_rs_data_i, id_rt_data_i  in  DATA_WIDTH each  register file read data
- id_imm_i  in  DATA_WIDTH  sign-extended immediate
- id_pc4_i  in  DATA_WIDTH  PC+4
- id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  in  1 each  control bits
- flush_i  in  1  branch/jump resolved taken in EX; kill the instruction in ID
- ex_valid_o  out  1  EX holds a real instruction
- ex_opcode_o, ex_func_o  out  6 each; ex_shamt_o  out  5
- ex_rs_o, ex_rt_o, ex_rd_o  out  5 each
- ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o  out  DATA_WIDTH each
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o  out  1 each
- stall_o  out  1  combinational; PC and IF/ID must hold this cycle
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each  saturating event counters

## Operation
- Hazard (combinational): hazard = ex_valid_o & ex_mem_read_o & id_valid_i & (ex_rt_o != 0) & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
- stall_o = hazard & ~flush_i.
- Per-edge update of the ID/EX register, in priority order:
  1. flush_i=1: load a bubble.
  2. stall_o=1: load a bubble.
  3. Otherwise: load all id_* inputs. ex_valid_o takes id_valid_i.
- Bubble contents:
  - valid=0 and all four control bits=0.
  - opcode=6'h3F and func=6'h3F, so the downstream shift decoder (SLL = 0/0, SRL = 0/2) never flags a shift on a bubble.
  - shamt, specifiers and data are all 0.
- When id_valid_i=0 with no stall and no flush, the loaded fields pass through, but control bits are forced to 0 and opcode/func are forced to 6'h3F (bubble semantics).
- Counters:
  - stall_cnt_o increments on every edge with stall_o=1.
  - flush_cnt_o increments on every edge with flush_i=1.
  - Both saturate at all-ones and never wrap.
- No internal FSM beyond the register. A stall lasts exactly one cycle per load, because the inserted bubble clears ex_mem_read_o.

## Timing
- Reset (reset=0, asynchronous): every ex_* output takes bubble values (ex_valid_o=0, controls 0, opcode/func 6'h3F, the rest 0). Both counters go to 0. stall_o=0 because ex_valid_o=0.
- Latency: an id_* value is visible on ex_* one clk edge after capture.
- stall_o is combinational from ex_* state and id_rs_i/id_rt_i, in the same cycle. There is no registered delay.
- flush_i and a hazard in the same cycle: flush wins. stall_o=0, one bubble is loaded, flush_cnt increments, stall_cnt does not.
- Back-to-back loads each feeding the next: the stall pattern alternates stall, issue, stall, and so on. There is never a 2-cycle stall.
- Reset deasserting mid-stream: the first edge after release loads normally.

## Test plan
- Reset: drive reset=0 with random id_* inputs. Then ex_valid_o=0, ex_opcode_o=ex_func_o=6'h3F, ex_reg_write_o=0, stall_cnt_o=flush_cnt_o=0, stall_o=0.
- Pass-through: issue sll with opcode 0, func 0, shamt 4, rt_data 32'h0000_00F1, reg_write=1. Next cycle ex_* shows exactly those values, ex_valid_o=1, stall_o=0.
- Load-use: issue lw with rt=$8, then add with rs=$8. In the cycle the add is in ID, stall_o=1. The next edge loads a bubble (opcode 6'h3F, valid 0) and stall_cnt_o=1. The add then issues on the following edge with stall_o=0.
- $zero and non-hazard cases:
  - lw with rt=$0 followed by a use of $0 gives stall_o=0.
  - lw with rt=$8 followed by an instruction using $9/$10 gives stall_o=0.
- Flush versus stall: create a load-use hazard and assert flush_i=1 in the same cycle. Then stall_o=0, a bubble is loaded, flush_cnt_o=1 and stall_cnt_o is unchanged.
- Saturation: with CNT_WIDTH=4, force 20 consecutive flushes. flush_cnt_o holds at 4'hF and does not wrap to 0.
